// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: a Moore FSM that sequences fetch,
// decode, memory, ALU, branch and jump steps and drives the datapath selects.
// Optional feature macro: MC_BNE_EN adds bne support.
// The default build, with the macro undefined, treats opcode 000101 as illegal.
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    logic [3:0] state_next;
    logic       op_known;
    logic       is_bne;

    // True when the opcode has a decode path out of DECODE
    always_comb begin
        op_known = 1'b0;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
`ifdef MC_BNE_EN
            OP_BNE: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BRANCH;
`endif
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = memready ? MEMWB : MEMRD;
            MEMWR:   state_next = memready ? FETCH : MEMWR;
            EXECUTE: state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // State register; reset forces FETCH immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

`ifdef MC_BNE_EN
    logic bne_q;

    // Remember at decode whether the branch in flight is a bne
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bne_q <= 1'b0;
        end else if (state == DECODE) begin
            bne_q <= (op == OP_BNE);
        end
    end

    assign is_bne = bne_q;
`else
    assign is_bne = 1'b0;
`endif

    // Moore outputs from the registered state, plus the memready-gated fetch strobes and the decode-time illegal pulse
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_known;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = ~is_bne;
                bne     = is_bne;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction walks with memready tied high,
// memory stalls, illegal opcodes, asynchronous reset in mid-store and bne.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       memready;
    logic       iord, memwrite, irwrite, pcwrite, branch, bne;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    mc_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .memready (memready),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .bne      (bne),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: iord memwrite irwrite pcwrite branch bne regdst memtoreg
    //                regwrite alusrca alusrcb[1:0] pcsrc[1:0] aluop[1:0] illegal
    logic [16:0] outs;
    assign outs = {iord, memwrite, irwrite, pcwrite, branch, bne, regdst, memtoreg,
                   regwrite, alusrca, alusrcb, pcsrc, aluop, illegal};

    localparam logic [16:0] O_FETCH   = 17'b0_0_1_1_0_0_0_0_0_0_01_00_00_0; // memready=1
    localparam logic [16:0] O_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MEMRD   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MEMWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_MEMWR   = 17'b1_1_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_EXECUTE = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] O_ALUWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_BRANCH  = 17'b0_0_0_0_1_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_BNEBR   = 17'b0_0_0_0_0_1_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_ADDIEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] O_JUMP    = 17'b0_0_0_1_0_0_0_0_0_0_00_10_00_0;
    localparam logic [16:0] O_ILLDEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected output bundle for a state with memready=1; mode 1 = illegal op, 2 = bne
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input int mode);
        case (st)
            4'd0:  return O_FETCH;
            4'd1:  return (mode == 1) ? O_ILLDEC : O_DECODE;
            4'd2:  return O_MEMADR;
            4'd3:  return O_MEMRD;
            4'd4:  return O_MEMWB;
            4'd5:  return O_MEMWR;
            4'd6:  return O_EXECUTE;
            4'd7:  return O_ALUWB;
            4'd8:  return (mode == 2) ? O_BNEBR : O_BRANCH;
            4'd9:  return O_ADDIEX;
            4'd10: return O_ADDIWB;
            4'd11: return O_JUMP;
            default: return 17'd0;
        endcase
    endfunction

    // Walk one instruction with memready=1; seq holds the state per cycle, one nibble each
    task automatic run_instr(input string tag, input logic [5:0] opc, input int n,
                             input logic [31:0] seq, input int mode);
        logic [3:0] st;
        for (int i = 0; i < n; i++) begin
            st = seq[4*i +: 4];
            op = opc;
            memready = 1'b1;
            #1;
            chk({tag, "_state"}, {28'd0, state}, {28'd0, st});
            chk({tag, "_outs"}, {15'd0, outs}, {15'd0, exp_outs(st, mode)});
            tick();
        end
        #1;
        chk({tag, "_done"}, {28'd0, state}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        op = 6'd0;
        memready = 1'b0;
        #2;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_irwrite", {31'd0, irwrite}, 32'd0);
        chk("rst_pcwrite", {31'd0, pcwrite}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_alusrcb", {30'd0, alusrcb}, 32'd1);
        tick();
        chk("fetch_hold_state", {28'd0, state}, 32'd0);
        chk("fetch_hold_irwrite", {31'd0, irwrite}, 32'd0);

        // Latencies: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2
        run_instr("lw",   6'b100011, 5, 32'h0004_3210, 0);
        run_instr("sw",   6'b101011, 4, 32'h0000_5210, 0);
        run_instr("rtype",6'b000000, 4, 32'h0000_7610, 0);
        run_instr("addi", 6'b001000, 4, 32'h0000_A910, 0);
        run_instr("beq",  6'b000100, 3, 32'h0000_0810, 0);
        run_instr("j",    6'b000010, 3, 32'h0000_0B10, 0);
        run_instr("ill",  6'b111111, 2, 32'h0000_0010, 1);
`ifdef MC_BNE_EN
        run_instr("bne",  6'b000101, 3, 32'h0000_0810, 2);
        run_instr("beq2", 6'b000100, 3, 32'h0000_0810, 0);
`else
        run_instr("bne_ill", 6'b000101, 2, 32'h0000_0010, 1);
`endif

        // Store with memory stalled three cycles in MEMWR
        op = 6'b101011;
        memready = 1'b1;
        tick();
        tick();
        chk("swst_memadr", {28'd0, state}, 32'd2);
        memready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("swst_state", {28'd0, state}, 32'd5);
            chk("swst_memwrite", {31'd0, memwrite}, 32'd1);
            tick();
        end
        memready = 1'b1;
        #1;
        chk("swst_last_state", {28'd0, state}, 32'd5);
        chk("swst_last_memwrite", {31'd0, memwrite}, 32'd1);
        tick();
        chk("swst_exit", {28'd0, state}, 32'd0);

        // Load stalled one cycle in MEMRD
        op = 6'b100011;
        tick();
        tick();
        memready = 1'b0;
        tick();
        chk("lwst_memrd", {28'd0, state}, 32'd3);
        tick();
        chk("lwst_memrd_hold", {28'd0, state}, 32'd3);
        memready = 1'b1;
        tick();
        chk("lwst_memwb", {28'd0, state}, 32'd4);
        tick();
        chk("lwst_exit", {28'd0, state}, 32'd0);

        // Asynchronous reset while a store is stalled in MEMWR
        op = 6'b101011;
        tick();
        tick();
        memready = 1'b0;
        tick();
        chk("rstwr_pre", {28'd0, state}, 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstwr_state", {28'd0, state}, 32'd0);
        chk("rstwr_memwrite", {31'd0, memwrite}, 32'd0);
        chk("rstwr_iord", {31'd0, iord}, 32'd0);
        chk("rstwr_irwrite", {31'd0, irwrite}, 32'd0);
        tick();
        chk("rstwr_held", {28'd0, state}, 32'd0);
        memready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rstwr_rel_irwrite", {31'd0, irwrite}, 32'd1);
        chk("rstwr_rel_state", {28'd0, state}, 32'd0);
        tick();
        chk("rstwr_first_edge", {28'd0, state}, 32'd1);
        tick();
        tick();
        tick();
        chk("rstwr_sw_done", {28'd0, state}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; state encoding is fixed by REQ-014.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-003 op  input  6  opcode of the instruction register, instr[31:26].
REQ-004 memready  input  1  memory completes the current access this cycle.
REQ-005 iord, memwrite, irwrite, pcwrite, branch, bne  output  1 each  datapath strobes/selects.
REQ-006 regdst, memtoreg, regwrite, alusrca  output  1 each  datapath selects/strobe.
REQ-007 alusrcb, pcsrc, aluop  output  2 each  mux selects; aluop feeds the ALU decoder (00 add, 01 sub, 10 use funct).
REQ-008 illegal  output  1  one-cycle pulse on an unrecognised opcode.
REQ-009 state  output  4  current state, for debug.

Function
REQ-010 SHALL be a Moore FSM: every output is a pure function of the registered state, except irwrite, pcwrite in FETCH and illegal in DECODE, which also depend on inputs.
REQ-011 SHALL drive every output not listed for a state to 0.
REQ-012 SHALL advance state only on rising clk edges.
REQ-013 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, bne 000101 (see REQ-030).
REQ-014 States/encodings and outputs:
- FETCH 0: alusrcb=01, irwrite=pcwrite=memready.
- DECODE 1: alusrcb=11.
- MEMADR 2: alusrca=1, alusrcb=10.
- MEMRD 3: iord=1.
- MEMWB 4: memtoreg=1, regwrite=1.
- MEMWR 5: iord=1, memwrite=1.
- EXECUTE 6: alusrca=1, aluop=10.
- ALUWB 7: regdst=1, regwrite=1.
- BRANCH 8: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX 9: alusrca=1, alusrcb=10.
- ADDIWB 10: regwrite=1.
- JUMP 11: pcsrc=10, pcwrite=1.
REQ-015 FETCH SHALL hold while memready=0 and SHALL go to DECODE when memready=1.
REQ-016 DECODE SHALL go to: MEMADR on lw/sw; EXECUTE on R; BRANCH on beq; ADDIEX on addi; JUMP on j.
REQ-017 On any other opcode, DECODE SHALL return to FETCH with illegal=1 for that cycle only.
REQ-018 MEMADR SHALL go to MEMRD on lw and to MEMWR on sw.
REQ-019 MEMRD and MEMWR SHALL hold while memready=0 and exit when memready=1: MEMRD to MEMWB, MEMWR to FETCH.
REQ-020 While MEMWR holds, memwrite SHALL remain asserted.
REQ-021 MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL go to FETCH unconditionally.
REQ-022 EXECUTE SHALL go to ALUWB; ADDIEX SHALL go to ADDIWB.
REQ-023 Encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-024 Instruction latencies with memready tied 1 (cycles, FETCH to FETCH): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
REQ-025 op SHALL be sampled only in DECODE and MEMADR.

Reset
REQ-026 On rst_n=0 the state SHALL become FETCH immediately, regardless of clk, including mid-instruction; no write strobe may remain asserted afterwards except FETCH irwrite/pcwrite gated by memready.
REQ-027 While rst_n=0 the state SHALL remain FETCH; the first edge after deassertion SHALL evaluate FETCH normally.

Configuration
REQ-028 SHALL have exactly one macro, MC_BNE_EN.
REQ-029 Without MC_BNE_EN: bne output SHALL be constant 0 and opcode 000101 SHALL be illegal (REQ-017).
REQ-030 With MC_BNE_EN: DECODE SHALL go to BRANCH on opcode 000101, and BRANCH SHALL then assert bne=1, branch=0, with the remaining outputs per REQ-014.
REQ-031 With MC_BNE_EN, for beq, bne SHALL stay 0.

Verification
REQ-032 Reset mid-MEMWR (op=101011, memready=0): assert rst_n=0 -> state=0 and memwrite=0 at once; after release with memready=1 -> irwrite=1.
REQ-033 lw, memready=1 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-034 sw with memready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles, memwrite=1 throughout, then state=0.
REQ-035 R-type -> aluop=10 in state 6, then regdst=1 and regwrite=1 in state 7; beq -> aluop=01, branch=1, pcsrc=01 in state 8.
REQ-036 op=111111 -> illegal=1 for exactly one cycle in DECODE, then state=0.
REQ-037 op=000101: with MC_BNE_EN -> state 8 with bne=1, branch=0; without it -> illegal=1.
